// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
package alu_defs;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;
  localparam logic [3:0] OP_INC = 4'b1000;
  localparam logic [3:0] OP_DEC = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_CMP = 4'b1011;
  localparam logic [3:0] OP_ROR = 4'b1100;
  localparam logic [3:0] OP_CLR = 4'b1101;
  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_NOP = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier: one partial product per clock, WIDTH iterations per start.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_sum;

  // product is the accumulator after the current iteration, so the final
  // result is visible at the same edge the counter steps from 1 to 0
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = (cnt_q == CNT_W'(1));
  assign product = acc_sum;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input handshake, held result/flags and a multi-cycle MUL.
module alu_seq
  import alu_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             z_flag,
  output logic             c_flag,
  output logic             n_flag
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               z_q, z_d, c_q, c_d, n_q, n_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   alu_r;
  logic               alu_c;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Arithmetic ops run at WIDTH+1 bits so the top bit is the carry/borrow
  always_comb begin
    ext   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    case (op)
      OP_ADD: begin ext = {1'b0, a} + {1'b0, b};        alu_r = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_SUB: begin ext = {1'b0, a} - {1'b0, b};        alu_r = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_INC: begin ext = {1'b0, a} + (WIDTH+1)'(1);    alu_r = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_DEC: begin ext = {1'b0, a} - (WIDTH+1)'(1);    alu_r = ext[WIDTH-1:0]; alu_c = ext[WIDTH]; end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_NOT: alu_r = ~a;
      OP_SHL: begin alu_r = {a[WIDTH-2:0], 1'b0};       alu_c = a[WIDTH-1]; end
      OP_SHR: begin alu_r = {1'b0, a[WIDTH-1:1]};       alu_c = a[0];       end
      OP_ROL: begin alu_r = {a[WIDTH-2:0], a[WIDTH-1]}; alu_c = a[WIDTH-1]; end
      OP_ROR: begin alu_r = {a[0], a[WIDTH-1:1]};       alu_c = a[0];       end
      default: begin alu_r = '0; alu_c = 1'b0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    z_d         = z_q;
    c_d         = c_q;
    n_d         = n_q;
    out_valid_d = 1'b0;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          case (op)
            OP_MUL: begin
              mul_start   = 1'b1;
              state_d     = ST_MUL;
              out_valid_d = 1'b0;
            end
            OP_CMP: begin
              z_d = (a == b);
              n_d = (a < b);
              c_d = (a > b);
            end
            OP_CLR: begin
              out_d = '0;
              z_d   = 1'b1;
              c_d   = 1'b0;
              n_d   = 1'b0;
            end
            OP_NOP: ;
            default: begin
              out_d = alu_r;
              c_d   = alu_c;
              z_d   = (alu_r == '0);
              n_d   = alu_r[WIDTH-1];
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          out_d       = mul_product[WIDTH-1:0];
          c_d         = |mul_product[2*WIDTH-1:WIDTH];
          z_d         = (mul_product[WIDTH-1:0] == '0);
          n_d         = mul_product[WIDTH-1];
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      z_q         <= z_d;
      c_q         <= c_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign z_flag    = z_q;
  assign c_flag    = c_q;
  assign n_flag    = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
  import alu_defs::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, out_valid8, z8, c8, n8;
  logic [7:0] a8, b8, out8;
  logic [3:0] op8;

  logic        in_valid16, in_ready16, out_valid16, z16, c16, n16;
  logic [15:0] a16, b16, out16;
  logic [3:0]  op16;

  int total_checks = 0;
  int passed_checks = 0;

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .op(op8), .out_valid(out_valid8), .out(out8),
    .z_flag(z8), .c_flag(c8), .n_flag(n8)
  );

  alu_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .op(op16), .out_valid(out_valid16), .out(out16),
    .z_flag(z16), .c_flag(c16), .n_flag(n16)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed === expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
  endtask

  // Drive one 8-bit operation for a single accepting edge; returns at the following negedge.
  task automatic applyStimulus(input logic [3:0] op_v, input logic [7:0] a_v, input logic [7:0] b_v);
    @(negedge clk);
    op8 = op_v; a8 = a_v; b8 = b_v; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  task automatic checkResult8(input string tag, input logic [7:0] e_out, input logic e_z, input logic e_c, input logic e_n);
    checkOutput({tag, ".valid"}, out_valid8, 1);
    checkOutput({tag, ".out"}, out8, e_out);
    checkOutput({tag, ".z"}, z8, e_z);
    checkOutput({tag, ".c"}, c8, e_c);
    checkOutput({tag, ".n"}, n8, e_n);
  endtask

  // Launch an 8-bit MUL and wait for its result, measuring latency and busy cycles.
  task automatic mul8(input string tag, input logic [7:0] a_v, input logic [7:0] b_v,
                      input logic [7:0] e_out, input logic e_c, input logic e_n);
    int lat;
    int busy;
    bit seen;
    @(negedge clk);
    op8 = OP_MUL; a8 = a_v; b8 = b_v; in_valid8 = 1'b1;
    lat = 0; busy = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      in_valid8 = 1'b0;
      a8 = 8'hA5; b8 = 8'h5A; op8 = OP_ADD;
      lat++;
      if (!in_ready8) busy++;
      if (out_valid8) seen = 1;
    end
    checkOutput({tag, ".seen"}, 32'(seen), 1);
    checkOutput({tag, ".latency"}, lat, 9);
    checkOutput({tag, ".busy"}, busy, 8);
    checkOutput({tag, ".ready"}, in_ready8, 1);
    checkResult8(tag, e_out, (e_out == 8'd0), e_c, e_n);
  endtask

  initial begin
    int lat;
    int pulses;
    bit seen;
    rst = 1'b1;
    in_valid8 = 0; a8 = 0; b8 = 0; op8 = 0;
    in_valid16 = 0; a16 = 0; b16 = 0; op16 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst.out", out8, 0);
    checkOutput("rst.flags", {z8, c8, n8}, 0);
    checkOutput("rst.valid", out_valid8, 0);
    checkOutput("rst.ready", in_ready8, 1);

    applyStimulus(OP_ADD, 8'd10, 8'd5);   checkResult8("add1", 8'd15, 0, 0, 0);
    applyStimulus(OP_ADD, 8'd200, 8'd100); checkResult8("add2", 8'd44, 0, 1, 0);
    @(negedge clk);
    checkOutput("valid.pulse", out_valid8, 0);
    checkOutput("hold.out", out8, 44);

    applyStimulus(OP_SUB, 8'd5, 8'd10);   checkResult8("sub1", 8'd251, 0, 1, 1);
    applyStimulus(OP_DEC, 8'd0, 8'd0);    checkResult8("dec0", 8'd255, 0, 1, 1);
    applyStimulus(OP_SUB, 8'd7, 8'd7);    checkResult8("sub0", 8'd0, 1, 0, 0);
    applyStimulus(OP_ROL, 8'b10000001, 8'd0); checkResult8("rol", 8'b00000011, 0, 1, 0);
    applyStimulus(OP_ROR, 8'b10000001, 8'd0); checkResult8("ror", 8'b11000000, 0, 1, 1);
    applyStimulus(OP_CMP, 8'd20, 8'd50);  checkResult8("cmplt", 8'b11000000, 0, 0, 1);
    applyStimulus(OP_CMP, 8'd100, 8'd30); checkResult8("cmpgt", 8'b11000000, 0, 1, 0);
    applyStimulus(OP_CMP, 8'd42, 8'd42);  checkResult8("cmpeq", 8'b11000000, 1, 0, 0);

    mul8("mul1", 8'd13, 8'd11, 8'd143, 0, 1);
    mul8("mul2", 8'd200, 8'd3, 8'd88, 1, 0);

    // CLR then NOP with in_valid held high across both edges
    @(negedge clk);
    op8 = OP_CLR; a8 = 8'd9; in_valid8 = 1'b1;
    @(negedge clk);
    checkResult8("clr", 8'd0, 1, 0, 0);
    op8 = OP_NOP; a8 = 8'd77; b8 = 8'd1;
    @(negedge clk);
    in_valid8 = 1'b0;
    checkResult8("nop", 8'd0, 1, 0, 0);

    // in_valid pulsed while MUL is busy must be ignored
    @(negedge clk);
    op8 = OP_MUL; a8 = 8'd6; b8 = 8'd7; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    op8 = OP_ADD; a8 = 8'd1; b8 = 8'd1; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (out_valid8) pulses++;
    end
    checkOutput("busy.pulses", pulses, 1);
    checkOutput("busy.out", out8, 42);

    // Reset in the middle of a multiply aborts it silently
    @(negedge clk);
    op8 = OP_MUL; a8 = 8'd15; b8 = 8'd15; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort.busy", in_ready8, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort.ready", in_ready8, 1);
    checkOutput("abort.out", out8, 0);
    checkOutput("abort.valid", out_valid8, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid8) pulses++;
    end
    checkOutput("abort.nopulse", pulses, 0);

    // 16-bit instance: MUL latency and wide carry, then ADD wrap
    @(negedge clk);
    op16 = OP_MUL; a16 = 16'd300; b16 = 16'd300; in_valid16 = 1'b1;
    lat = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      in_valid16 = 1'b0;
      lat++;
      if (out_valid16) seen = 1;
    end
    checkOutput("mul16.seen", 32'(seen), 1);
    checkOutput("mul16.latency", lat, 17);
    checkOutput("mul16.out", out16, 24464);
    checkOutput("mul16.flags", {z16, c16, n16}, 3'b010);

    @(negedge clk);
    op16 = OP_ADD; a16 = 16'd65535; b16 = 16'd1; in_valid16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    checkOutput("add16.valid", out_valid16, 1);
    checkOutput("add16.out", out16, 0);
    checkOutput("add16.flags", {z16, c16, n16}, 3'b110);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
